// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit shared types and constants.
// Imported by the fetch unit and its helpers.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        BUBBLE,
        HALT
    } state_t;

    localparam logic [31:0] IMEM_BASE      = 32'd16;
    localparam logic [31:0] INSTR_BYTES    = 32'd4;
    localparam logic [31:0] RESET_PC_DEF   = 32'd16;
    localparam int unsigned IMEM_WORDS_DEF = 1024;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect/stall in, fetch address and status out.
// The fetch unit is the slave; decode/execute side is the master.
interface pc_fetch_unit_if;

    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] ImemIndex;
    logic        FetchValid;
    logic        OutOfRange;

    modport master (
        output Stall,
        output BranchTaken,
        output BranchTarget,
        input  PC,
        input  PCPlus4,
        input  ImemIndex,
        input  FetchValid,
        input  OutOfRange
    );

    modport slave (
        input  Stall,
        input  BranchTaken,
        input  BranchTarget,
        output PC,
        output PCPlus4,
        output ImemIndex,
        output FetchValid,
        output OutOfRange
    );

endinterface

// File: rtl/pc_fetch_unit_index.sv
// pc_index: byte address to instruction-memory word index.
// Also flags misaligned or out-of-window addresses.
module pc_index #(
    parameter logic [31:0] IMEM_BASE  = pc_fetch_unit_pkg::IMEM_BASE,
    parameter int unsigned IMEM_WORDS = pc_fetch_unit_pkg::IMEM_WORDS_DEF
) (
    input  logic [31:0] addr,
    output logic [31:0] index,
    output logic        oor
);

    logic [31:0] offs;

    assign offs  = addr - IMEM_BASE;
    assign index = offs >> 2;

    // Wrap past the top of the address space lands below the base.
    assign oor = (addr[1:0] != 2'b00)
              || (addr < IMEM_BASE)
              || (index >= IMEM_WORDS);

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with stall, redirect bubble
// and sticky out-of-range halt.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = pc_fetch_unit_pkg::RESET_PC_DEF,
    parameter int unsigned IMEM_WORDS = pc_fetch_unit_pkg::IMEM_WORDS_DEF,
    parameter logic [31:0] IMEM_BASE  = pc_fetch_unit_pkg::IMEM_BASE
) (
    input logic            Clk,
    input logic            Rst,
    pc_fetch_unit_if.slave bus
);

    import pc_fetch_unit_pkg::*;

    localparam logic [31:0] RESET_IDX = (RESET_PC - IMEM_BASE) >> 2;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] idx_q, idx_d;
    logic        oor_d;

    pc_index #(
        .IMEM_BASE  (IMEM_BASE),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_index (
        .addr  (pc_d),
        .index (idx_d),
        .oor   (oor_d)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT: begin
                pc_d    = RESET_PC;
                state_d = RUN;
            end
            RUN: begin
                if (bus.BranchTaken) begin
                    pc_d    = bus.BranchTarget;
                    state_d = BUBBLE;
                end else if (!bus.Stall) begin
                    pc_d = pc_q + INSTR_BYTES;
                end
            end
            BUBBLE: begin
                if (bus.BranchTaken) begin
                    pc_d    = bus.BranchTarget;
                    state_d = BUBBLE;
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
        endcase
        // Halt freezes the PC at the offending next value.
        if (oor_d) begin
            state_d = HALT;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            idx_q   <= RESET_IDX;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_q + INSTR_BYTES;
    assign bus.ImemIndex  = idx_q;
    assign bus.FetchValid = (state_q == RUN);
    assign bus.OutOfRange = (state_q == HALT);

endmodule
